// File: rtl/pwm_multi_ch_if.sv
// Control/status bundle between a bus-side master and the multi-channel PWM block.
interface pwm_multi_ch_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int PRE_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              enable;
  logic [PRE_W-1:0]  pre_div;
  logic [CNT_W-1:0]  period_in;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [CNT_W-1:0]  wr_duty;
  logic [NUM_CH-1:0] pwm_out;
  logic              cycle_start;

  modport master (
    output enable, pre_div, period_in, wr_en, wr_ch, wr_duty,
    input  pwm_out, cycle_start
  );

  modport slave (
    input  enable, pre_div, period_in, wr_en, wr_ch, wr_duty,
    output pwm_out, cycle_start
  );
endinterface

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: shared prescaler/period counter, per-channel double-buffered duty.
// Define PWM_CENTER_ALIGN_EN for an up/down (center-aligned) counter instead of edge-aligned.
module pwm_multi_ch_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             load_i,
  input  logic             wr_sel_i,
  input  logic [CNT_W-1:0] wr_duty_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             pwm_o
);
  logic [CNT_W-1:0] duty_sh_q, duty_act_q;
  logic             pwm_q, pwm_d;

  assign pwm_d = enable_i & (cnt_i < duty_act_q);
  assign pwm_o = pwm_q;

  // Active takes the pre-write shadow when a write lands on a load edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      duty_sh_q  <= '0;
      duty_act_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      if (wr_sel_i) duty_sh_q  <= wr_duty_i;
      if (load_i)   duty_act_q <= duty_sh_q;
      pwm_q <= pwm_d;
    end
  end
endmodule

module pwm_multi_ch #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int PRE_W  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_multi_ch_if.slave   bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, period_act_q;
  logic              cs_q, tick, period_end, load;
  logic [NUM_CH-1:0] pwm_w;
`ifdef PWM_CENTER_ALIGN_EN
  logic              dir_q, dir_d;
`endif

  always_comb begin
    tick       = bus.enable && (pre_q == bus.pre_div);
    pre_d      = (!bus.enable || tick) ? '0 : pre_q + PRE_W'(1);
    cnt_d      = cnt_q;
    period_end = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
    dir_d = dir_q;
    if (!bus.enable) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (tick) begin
      if (period_act_q == '0) begin
        period_end = 1'b1;
      end else if (!dir_q && (cnt_q != period_act_q)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        // Peak turnaround or down ramp; a peak of 1 returns straight to 0.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          period_end = 1'b1;
          dir_d      = 1'b0;
        end else begin
          dir_d = 1'b1;
        end
      end
    end
`else
    if (!bus.enable) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == period_act_q) begin
        cnt_d      = '0;
        period_end = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif
    load = period_end || !bus.enable;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q        <= '0;
      cnt_q        <= '0;
      period_act_q <= '0;
      cs_q         <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_q        <= 1'b0;
`endif
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      cs_q  <= bus.enable & period_end;
      if (load) period_act_q <= bus.period_in;
`ifdef PWM_CENTER_ALIGN_EN
      dir_q <= dir_d;
`endif
    end
  end

  // Channel index decode also discards writes to channels that do not exist.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    pwm_multi_ch_lane #(.CNT_W(CNT_W)) u_lane (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .enable_i  (bus.enable),
      .load_i    (load),
      .wr_sel_i  (bus.wr_en && (bus.wr_ch == CH_W'(i))),
      .wr_duty_i (bus.wr_duty),
      .cnt_i     (cnt_q),
      .pwm_o     (pwm_w[i])
    );
  end

  assign bus.pwm_out     = pwm_w;
  assign bus.cycle_start = cs_q;
endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch (default edge-aligned build, 4 channels, 8-bit).
module tb_pwm_multi_ch;
  localparam int NUM_CH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int         hi_cnt [NUM_CH];
  int         cs_cnt, cs_first;
  logic [3:0] pwm_hist [64];

  pwm_multi_ch_if #(.NUM_CH(NUM_CH), .CNT_W(8), .PRE_W(8)) bus ();

  pwm_multi_ch #(.NUM_CH(NUM_CH), .CNT_W(8), .PRE_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int ch, input int val);
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 2'(ch);
    bus.wr_duty = 8'(val);
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic run_window(input int n);
    for (int c = 0; c < NUM_CH; c++) hi_cnt[c] = 0;
    cs_cnt   = 0;
    cs_first = -1;
    for (int k = 0; k < n; k++) begin
      step();
      pwm_hist[k] = bus.pwm_out;
      for (int c = 0; c < NUM_CH; c++) hi_cnt[c] += int'(bus.pwm_out[c]);
      if (bus.cycle_start) begin
        cs_cnt++;
        if (cs_first < 0) cs_first = k + 1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.enable = 1'b1;
    bus.pre_div = 8'd0;
    bus.period_in = 8'd9;
    repeat (3) step();
    checks++; if (bus.pwm_out !== 4'b0000) begin errors++; $display("FAIL reset_pwm got %b want 0000", bus.pwm_out); end
    checks++; if (bus.cycle_start !== 1'b0) begin errors++; $display("FAIL reset_cs got %b want 0", bus.cycle_start); end
    checks++; if (dut.cnt_q !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", dut.cnt_q); end
    bus.enable = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int exp_hi [NUM_CH];
    exp_hi = '{0, 6, 10, 20};
    bus.pre_div = 8'd0;
    bus.period_in = 8'd9;
    do_write(0, 0);
    do_write(1, 3);
    do_write(2, 5);
    do_write(3, 10);
    step();
    bus.enable = 1'b1;
    run_window(20);
    checks++; if (pwm_hist[0] !== 4'b1110) begin errors++; $display("FAIL basic_cnt0 got %b want 1110", pwm_hist[0]); end
    checks++; if (pwm_hist[3] !== 4'b1100) begin errors++; $display("FAIL basic_cnt3 got %b want 1100", pwm_hist[3]); end
    checks++; if (pwm_hist[5] !== 4'b1000) begin errors++; $display("FAIL basic_cnt5 got %b want 1000", pwm_hist[5]); end
    checks++; if (pwm_hist[9] !== 4'b1000) begin errors++; $display("FAIL basic_cnt9 got %b want 1000", pwm_hist[9]); end
    for (int c = 0; c < NUM_CH; c++) begin
      checks++;
      if (hi_cnt[c] !== exp_hi[c]) begin errors++; $display("FAIL basic_hi_ch%0d got %0d want %0d", c, hi_cnt[c], exp_hi[c]); end
    end
    checks++; if (cs_cnt !== 2) begin errors++; $display("FAIL basic_cs_count got %0d want 2", cs_cnt); end
    checks++; if (cs_first !== 10) begin errors++; $display("FAIL basic_cs_first got %0d want 10", cs_first); end
  endtask

  task automatic test_prescale();
    bus.enable = 1'b0;
    bus.pre_div = 8'd3;
    bus.period_in = 8'd4;
    do_write(1, 2);
    step();
    bus.enable = 1'b1;
    run_window(40);
    checks++; if (hi_cnt[1] !== 16) begin errors++; $display("FAIL pre_hi_ch1 got %0d want 16", hi_cnt[1]); end
    checks++; if (cs_cnt !== 2) begin errors++; $display("FAIL pre_cs_count got %0d want 2", cs_cnt); end
    checks++; if (cs_first !== 20) begin errors++; $display("FAIL pre_cs_first got %0d want 20", cs_first); end
  endtask

  task automatic test_duty_update();
    int per [5];
    int exp_per [5];
    exp_per = '{2, 7, 7, 7, 3};
    per = '{0, 0, 0, 0, 0};
    bus.enable = 1'b0;
    bus.pre_div = 8'd0;
    bus.period_in = 8'd9;
    do_write(1, 2);
    step();
    bus.enable = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      step();
      per[(k - 1) / 10] += int'(bus.pwm_out[1]);
      // Write lands mid-period on k=5, exactly on the period_end edge on k=29.
      if (k == 5)  begin bus.wr_en = 1'b1; bus.wr_ch = 2'd1; bus.wr_duty = 8'd7; end
      if (k == 29) begin bus.wr_en = 1'b1; bus.wr_ch = 2'd1; bus.wr_duty = 8'd3; end
      if (k == 6 || k == 30) bus.wr_en = 1'b0;
    end
    for (int p = 0; p < 5; p++) begin
      checks++;
      if (per[p] !== exp_per[p]) begin errors++; $display("FAIL upd_period%0d_hi got %0d want %0d", p, per[p], exp_per[p]); end
    end
  endtask

  task automatic test_enable();
    int n;
    n = 0;
    while (bus.cycle_start !== 1'b1 && n < 30) begin step(); n++; end
    checks++; if (n >= 30) begin errors++; $display("FAIL en_wait_cs got timeout want cycle_start"); end
    step();
    checks++; if (bus.pwm_out[1] !== 1'b1) begin errors++; $display("FAIL en_midpulse got %b want 1", bus.pwm_out[1]); end
    bus.enable = 1'b0;
    step();
    checks++; if (bus.pwm_out !== 4'b0000) begin errors++; $display("FAIL en_drop_pwm got %b want 0000", bus.pwm_out); end
    checks++; if (bus.cycle_start !== 1'b0) begin errors++; $display("FAIL en_drop_cs got %b want 0", bus.cycle_start); end
    checks++; if (dut.cnt_q !== 8'd0) begin errors++; $display("FAIL en_drop_cnt got %0d want 0", dut.cnt_q); end
    do_write(1, 5);
    bus.period_in = 8'd4;
    bus.pre_div = 8'd1;
    step();
    bus.enable = 1'b1;
    run_window(10);
    checks++; if (cs_first !== 10) begin errors++; $display("FAIL en_restart_cs got %0d want 10", cs_first); end
    checks++; if (hi_cnt[1] !== 10) begin errors++; $display("FAIL en_restart_hi_ch1 got %0d want 10", hi_cnt[1]); end
  endtask

  task automatic test_reset_mid();
    int tot;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    checks++; if (bus.pwm_out !== 4'b0000) begin errors++; $display("FAIL rmid_pwm got %b want 0000", bus.pwm_out); end
    checks++; if (bus.cycle_start !== 1'b0) begin errors++; $display("FAIL rmid_cs got %b want 0", bus.cycle_start); end
    checks++; if (dut.cnt_q !== 8'd0) begin errors++; $display("FAIL rmid_cnt got %0d want 0", dut.cnt_q); end
    rst_n = 1'b1;
    run_window(10);
    tot = hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3];
    checks++; if (tot !== 0) begin errors++; $display("FAIL rmid_duty_cleared got %0d want 0", tot); end
  endtask

  initial begin
    bus.enable    = 1'b0;
    bus.pre_div   = 8'd0;
    bus.period_in = 8'd0;
    bus.wr_en     = 1'b0;
    bus.wr_ch     = 2'd0;
    bus.wr_duty   = 8'd0;
    test_reset();
    test_basic();
    test_prescale();
    test_duty_update();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
